// File: rtl/sort_pkg.sv
// Shared definitions for the odd-even transposition sort engine:
// FSM state encodings, phase parity constants and the swap counter width.
package sort_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_SORT = 2'b10,
        ST_DISP = 2'b11
    } state_t;

    localparam logic PHASE_EVEN = 1'b0;
    localparam logic PHASE_ODD  = 1'b1;

    localparam int SWAP_CNT_W = 16;

endpackage

// File: rtl/sort_engine_if.sv
// Handshake and data bus of the sort engine. The master side presents the
// unsorted array and the button level; the slave side returns the sorted array.
interface sort_engine_if
    import sort_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 4
);

    logic                  btn;
    logic                  desc;
    logic [N*W-1:0]        din;
    logic [N*W-1:0]        dout;
    logic                  busy;
    logic                  done;
    logic [SWAP_CNT_W-1:0] swap_cnt;

    modport master (
        output btn, desc, din,
        input  dout, busy, done, swap_cnt
    );

    modport slave (
        input  btn, desc, din,
        output dout, busy, done, swap_cnt
    );

endinterface

// File: rtl/sort_cmp_swap.sv
// Combinational compare-exchange cell: lo_out lands in the lower index of the
// pair, hi_out in the upper index. Equal values pass straight through.
module sort_cmp_swap #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         desc,
    output logic [W-1:0] lo_out,
    output logic [W-1:0] hi_out,
    output logic         swapped
);

    always_comb begin
        swapped = desc ? (a < b) : (a > b);
        lo_out  = swapped ? b : a;
        hi_out  = swapped ? a : b;
    end

endmodule

// File: rtl/sort_engine.sv
// Odd-even transposition sorter: loads N words on a button press, runs one
// compare-exchange phase per clock, exits early once two phases see no swaps.
module sort_engine
    import sort_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 4
) (
    input logic          clk,
    input logic          rst_n,
    sort_engine_if.slave bus
);

    localparam int PH_W  = $clog2(N);
    localparam int CNT_W = $clog2(N/2 + 1);
    localparam int NP    = N - 1;

    state_t                state_q, state_d;
    logic [PH_W-1:0]       phase_q;
    logic                  mode_q;
    logic                  prev_swap_q;
    logic [N*W-1:0]        arr_q, arr_d;
    logic [SWAP_CNT_W-1:0] swap_cnt_q;

    logic [NP*W-1:0]       cell_lo, cell_hi;
    logic [NP-1:0]         cell_sw, pair_act;
    logic [CNT_W-1:0]      n_swaps;
    logic                  any_swap;
    logic                  sort_exit;

    function automatic logic [SWAP_CNT_W-1:0] sat_add(
        input logic [SWAP_CNT_W-1:0] acc,
        input logic [CNT_W-1:0]      inc
    );
        logic [SWAP_CNT_W:0] sum;
        sum = {1'b0, acc} + (SWAP_CNT_W+1)'(inc);
        return sum[SWAP_CNT_W] ? '1 : sum[SWAP_CNT_W-1:0];
    endfunction

    // One cell per adjacent pair; pairs starting at an even index form the
    // even network, the rest the odd network, selected by phase parity.
    genvar i;
    generate
        for (i = 0; i < NP; i++) begin : g_pair
            sort_cmp_swap #(.W(W)) u_cmp (
                .a       (arr_q[i*W +: W]),
                .b       (arr_q[(i+1)*W +: W]),
                .desc    (mode_q),
                .lo_out  (cell_lo[i*W +: W]),
                .hi_out  (cell_hi[i*W +: W]),
                .swapped (cell_sw[i])
            );
            assign pair_act[i] = (phase_q[0] == (((i % 2) == 0) ? PHASE_EVEN : PHASE_ODD));
        end
    endgenerate

    always_comb begin
        arr_d   = arr_q;
        n_swaps = '0;
        for (int k = 0; k < NP; k++) begin
            if (pair_act[k]) begin
                arr_d[k*W +: W]     = cell_lo[k*W +: W];
                arr_d[(k+1)*W +: W] = cell_hi[k*W +: W];
                if (cell_sw[k]) n_swaps = n_swaps + CNT_W'(1);
            end
        end
        any_swap = |(cell_sw & pair_act);
    end

    assign sort_exit = (phase_q == PH_W'(N-1)) ||
                       ((phase_q != '0) && !any_swap && !prev_swap_q);

    always_comb begin
        state_d  = state_q;
        bus.busy = (state_q == ST_LOAD) || (state_q == ST_SORT);
        bus.done = (state_q == ST_DISP);
        case (state_q)
            ST_IDLE: if (bus.btn)   state_d = ST_LOAD;
            ST_LOAD:                state_d = ST_SORT;
            ST_SORT: if (sort_exit) state_d = ST_DISP;
            ST_DISP: if (!bus.btn)  state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            arr_q       <= '0;
            mode_q      <= 1'b0;
            phase_q     <= '0;
            prev_swap_q <= 1'b0;
            swap_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_LOAD: begin
                    arr_q       <= bus.din;
                    mode_q      <= bus.desc;
                    phase_q     <= '0;
                    prev_swap_q <= 1'b1;
                    swap_cnt_q  <= '0;
                end
                ST_SORT: begin
                    arr_q       <= arr_d;
                    swap_cnt_q  <= sat_add(swap_cnt_q, n_swaps);
                    prev_swap_q <= any_swap;
                    if (!sort_exit) phase_q <= phase_q + PH_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.dout     = arr_q;
    assign bus.swap_cnt = swap_cnt_q;

endmodule

// File: tb/tb_sort_engine.sv
// Directed bench for sort_engine: N=4/W=8 scenarios with hand-computed results
// plus an N=7/W=12 instance checked against a small sorting/inversion model.
module tb_sort_engine;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sort_engine_if #(.W(8),  .N(4)) bus4();
    sort_engine_if #(.W(12), .N(7)) bus7();

    sort_engine #(.W(8),  .N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    sort_engine #(.W(12), .N(7)) dut7 (.clk(clk), .rst_n(rst_n), .bus(bus7));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pk4(input logic [7:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic run4(input string tag, input logic [31:0] vin, input logic d,
                        input logic [31:0] exp, input int exp_cnt, input int exp_lat);
        int lat;
        lat = 0;
        bus4.din  = vin;
        bus4.desc = d;
        bus4.btn  = 1'b1;
        step();
        chk({tag, "_load_busy"}, 128'(bus4.busy), 128'(1));
        bus4.btn = 1'b0;
        while (!bus4.done && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        chk({tag, "_dout"}, 128'(bus4.dout), 128'(exp));
        chk({tag, "_swap_cnt"}, 128'(bus4.swap_cnt), 128'(exp_cnt));
        chk({tag, "_busy_disp"}, 128'(bus4.busy), 128'(0));
        step();
        chk({tag, "_idle_done"}, 128'(bus4.done), 128'(0));
        chk({tag, "_idle_hold"}, 128'(bus4.dout), 128'(exp));
    endtask

    task automatic run7(input string tag, input logic [83:0] vin, input logic d);
        logic [11:0] a [7];
        logic [11:0] t;
        logic [83:0] exp;
        int inv;
        int lat;
        inv = 0;
        lat = 0;
        for (int i = 0; i < 7; i++) a[i] = vin[i*12 +: 12];
        for (int i = 0; i < 7; i++)
            for (int j = i + 1; j < 7; j++)
                if (d ? (a[i] < a[j]) : (a[i] > a[j])) inv++;
        for (int i = 1; i < 7; i++)
            for (int j = i; j > 0; j--)
                if (d ? (a[j-1] < a[j]) : (a[j-1] > a[j])) begin
                    t = a[j]; a[j] = a[j-1]; a[j-1] = t;
                end
        for (int i = 0; i < 7; i++) exp[i*12 +: 12] = a[i];
        bus7.din  = vin;
        bus7.desc = d;
        bus7.btn  = 1'b1;
        step();
        bus7.btn = 1'b0;
        while (!bus7.done && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "_lat_bound"}, 128'(lat >= 3 && lat <= 8), 128'(1));
        chk({tag, "_dout"}, 128'(bus7.dout), 128'(exp));
        chk({tag, "_swap_cnt"}, 128'(bus7.swap_cnt), 128'(inv));
        step();
    endtask

    initial begin
        logic [83:0] v7;
        rst_n     = 1'b0;
        bus4.btn  = 1'b0;
        bus4.desc = 1'b0;
        bus4.din  = '0;
        bus7.btn  = 1'b0;
        bus7.desc = 1'b0;
        bus7.din  = '0;
        #12;
        chk("rst_dout", 128'(bus4.dout), 128'(0));
        chk("rst_busy", 128'(bus4.busy), 128'(0));
        chk("rst_done", 128'(bus4.done), 128'(0));
        chk("rst_cnt", 128'(bus4.swap_cnt), 128'(0));
        chk("rst7_dout", 128'(bus7.dout), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run4("asc", pk4(9, 3, 7, 1), 1'b0, pk4(1, 3, 7, 9), 5, 5);
        run4("desc", pk4(1, 2, 3, 4), 1'b1, pk4(4, 3, 2, 1), 6, 5);
        run4("sorted", pk4(1, 2, 3, 4), 1'b0, pk4(1, 2, 3, 4), 0, 3);
        run4("equal", pk4(5, 5, 5, 5), 1'b0, pk4(5, 5, 5, 5), 0, 3);

        // Reset asserted during the second SORT cycle
        bus4.din  = pk4(9, 3, 7, 1);
        bus4.desc = 1'b0;
        bus4.btn  = 1'b1;
        step();
        bus4.btn = 1'b0;
        step();
        step();
        chk("mid_busy_pre", 128'(bus4.busy), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 128'(bus4.busy), 128'(0));
        chk("mid_rst_done", 128'(bus4.done), 128'(0));
        chk("mid_rst_dout", 128'(bus4.dout), 128'(0));
        chk("mid_rst_cnt", 128'(bus4.swap_cnt), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run4("restart", pk4(9, 3, 7, 1), 1'b0, pk4(1, 3, 7, 9), 5, 5);

        // Button held through DISPLAY: no reload even with new input data
        bus4.din  = pk4(9, 3, 7, 1);
        bus4.desc = 1'b0;
        bus4.btn  = 1'b1;
        step();
        for (int c = 0; c < 20 && !bus4.done; c++) step();
        chk("hold_done_reached", 128'(bus4.done), 128'(1));
        bus4.din = pk4(0, 255, 128, 1);
        for (int c = 0; c < 3; c++) step();
        chk("hold_done", 128'(bus4.done), 128'(1));
        chk("hold_busy", 128'(bus4.busy), 128'(0));
        chk("hold_dout", 128'(bus4.dout), 128'(pk4(1, 3, 7, 9)));
        bus4.btn = 1'b0;
        step();
        chk("rel_done", 128'(bus4.done), 128'(0));
        chk("rel_busy", 128'(bus4.busy), 128'(0));
        chk("rel_dout", 128'(bus4.dout), 128'(pk4(1, 3, 7, 9)));
        chk("rel_cnt", 128'(bus4.swap_cnt), 128'(5));
        run4("newdata", pk4(0, 255, 128, 1), 1'b0, pk4(0, 1, 128, 255), 3, 5);

        // N=7, W=12 sweep
        for (int i = 0; i < 7; i++) v7[i*12 +: 12] = 12'(700 - 100 * i);
        run7("n7_rev_asc", v7, 1'b0);
        run7("n7_rev_desc", v7, 1'b1);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 7; i++) v7[i*12 +: 12] = 12'($urandom_range(0, 4095));
            run7("n7_rand_asc", v7, 1'b0);
            run7("n7_rand_desc", v7, 1'b1);
        end
        for (int i = 0; i < 7; i++) v7[i*12 +: 12] = 12'($urandom_range(0, 3));
        run7("n7_dups", v7, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sort_engine.md
# sort_engine

Parametrised sorting engine for N unsigned words of W bits. It captures a flat input vector on a button press and sorts it in place by odd-even transposition, one compare-exchange phase per clock, in ascending or descending order. It exits early once the array is sorted, then holds the result with a done indication until the button is released. It is the general replacement for fixed three-value sort controllers and integrates its own datapath; no external compare or mux control is needed.

## Interface
- W, 8, element width in bits (≥1)
- N, 4, element count (≥2)
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- btn  input  1  start/acknowledge level, already debounced and synchronised
- desc  input  1  order select, sampled at load: 0 ascending, 1 descending
- din  input  N*W  unsorted elements; element i = din[i*W +: W]
- dout  output  N*W  working/sorted array registers; element i = dout[i*W +: W]
- busy  output  1  high in LOAD and SORT
- done  output  1  high in DISPLAY
- swap_cnt  output  16  total exchanges performed in the current sort, saturating at 16'hFFFF

## Operation
- States: IDLE, LOAD, SORT, DISPLAY.
- IDLE: busy=0, done=0. btn=1 → LOAD, else stay.
- LOAD, one cycle: dout←din; mode←desc; phase←0; prev_swap←1; swap_cnt←0. Then → SORT.
- SORT, one cycle per phase p:
  - Even p compares pairs (0,1),(2,3),…; odd p compares pairs (1,2),(3,4),…
  - Pair (i,i+1) swaps when a[i]>a[i+1] (ascending) or a[i]<a[i+1] (descending). Equal values never swap, so the sort is stable.
  - Exchanges in the same phase are disjoint and update together at the clock edge.
  - any_swap = OR of this phase's exchanges. swap_cnt += number of exchanges, saturating.
- Exit SORT → DISPLAY when p==N-1, or when p≥1 && !any_swap && !prev_swap. Otherwise p←p+1, prev_swap←any_swap.
- DISPLAY: done=1, dout holds. btn=1 stays; btn=0 → IDLE. dout and swap_cnt hold through IDLE until the next LOAD.
- btn is ignored in LOAD and SORT.
- Unused state encodings → IDLE.

## Timing
- Reset (async assert, sync release): state IDLE; dout=0, busy=0, done=0, swap_cnt=0, phase=0.
- Reset mid-operation takes effect immediately; a partial sort is discarded.
- btn sampled high in IDLE at edge t:
  - LOAD occupies cycle t+1.
  - SORT occupies k cycles, 2≤k≤N.
  - done rises in cycle t+k+2.
- Worst-case latency from btn to done: N+2 cycles. Already sorted input: 4 cycles.
- dout is registered and changes only at LOAD and SORT edges. busy and done are Moore decodes of the state register.
- Phase counter width: $clog2(N). Swap-count adder width: $clog2(N/2+1) bits per phase, added into 16 bits with saturation.

## Structure
- Shared header sort_pkg: state encodings (2-bit), phase-parity constants, SWAP_CNT_W=16.
- Sub-module sort_cmp_swap (parameter W): combinational compare-exchange cell.
  - Inputs: a, b, desc. Outputs: lo_out, hi_out, swapped.
  - Instantiated per pair for the even and odd networks via generate.
- Top level holds the FSM, array registers, phase counter, termination logic and swap counter.

## Test plan
All scenarios use W=8, N=4; element 0 is listed first.
- Ascending, din={9,3,7,1}, btn pulse → dout={1,3,7,9}, swap_cnt=5, 4 SORT cycles, done 6 cycles after btn edge.
- Descending, din={1,2,3,4} → dout={4,3,2,1}, swap_cnt=6, 4 SORT cycles.
- Early exit: din={1,2,3,4} ascending, and separately din={5,5,5,5} → dout unchanged, swap_cnt=0, exactly 2 SORT cycles, done 4 cycles after btn.
- Reset mid-SORT: rst_n low during the 2nd SORT cycle → same cycle shows IDLE, dout=0, busy=0, swap_cnt=0. After release, btn restarts the sort cleanly.
- Handshake: btn held high through DISPLAY → done stays 1, no reload. btn low → IDLE next cycle with dout held. btn high with new din={0,255,128,1} → {0,1,128,255}.
- Parameter sweep: N=7, W=12, with reverse-sorted and random vectors against a reference model. Check exit in ≤N phases and swap_cnt equals the inversion count.
